// File: rtl/uart_tx_cfg_pkg.sv
// Shared definitions for the configurable UART: FSM states, parity codes and
// a counter-width helper, reusable by a future configurable receiver.
package uart_tx_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // Bits needed to hold 0..n-1, never less than one.
  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/uart_tx_cfg_baud.sv
// Baud timer: counts 0..DIV-1 while enabled, ticks on DIV-1 and flags DIV-2
// so the owner can register an end-of-bit event one cycle early.
module uart_baud_tick
  import uart_tx_cfg_pkg::*;
#(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic rstn,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o,
  output logic pre_o
);

  localparam int CW = clog2(DIV);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (en_i)
      cnt_d = (cnt_q == CW'(DIV - 1)) ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rstn) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign tick_o = en_i && (cnt_q == CW'(DIV - 1));
  assign pre_o  = en_i && (cnt_q == CW'(DIV - 2));

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: start, DATA_BITS payload LSB first,
// optional parity, 1 or 2 stop bits; tx/ready/done all registered.
module uart_tx_cfg
  import uart_tx_cfg_pkg::*;
#(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD      = 9600,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  input  logic [DATA_BITS-1:0] data,
  output logic                 tx,
  output logic                 ready,
  output logic                 done
);

  localparam int DIV = (CLK_FREQ + BAUD / 2) / BAUD;
  localparam int BW  = clog2(DATA_BITS);

  generate
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
      $error("uart_tx_cfg: DATA_BITS must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_par
      $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
      $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
    end
    if (DIV < 2) begin : g_bad_div
      $error("uart_tx_cfg: clock/baud divisor must be >= 2");
    end
  endgenerate

  state_e               state_q, state_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 par_q, par_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic                 tx_q, tx_d;
  logic                 ready_q, ready_d;
  logic                 done_q, done_d;
  logic                 tick, pre, accept, last_stop;

  assign accept    = start && ready_q;
  assign last_stop = (state_q == ST_STOP) && (bit_q == BW'(STOP_BITS - 1));

  uart_baud_tick #(.DIV(DIV)) u_baud (
    .clk    (clk),
    .rstn   (rstn),
    .en_i   (state_q != ST_IDLE),
    .clr_i  (accept),
    .tick_o (tick),
    .pre_o  (pre)
  );

  always_ff @(posedge clk) begin
    if (rstn) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (accept) state_d = ST_START;
      ST_START:  if (tick) state_d = ST_DATA;
      ST_DATA:
        if (tick && bit_q == BW'(DATA_BITS - 1))
          state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
      ST_PARITY: if (tick) state_d = ST_STOP;
      ST_STOP:   if (tick && last_stop) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Bit counter is shared by DATA and STOP and restarts on every state change.
  always_comb begin
    data_d = data_q;
    par_d  = par_q;
    bit_d  = bit_q;
    if (accept) begin
      data_d = data;
      par_d  = (PARITY == PAR_ODD) ? ~^data : ^data;
      bit_d  = '0;
    end else if (tick) begin
      bit_d = (state_d != state_q) ? '0 : bit_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      data_q <= '0;
      par_q  <= 1'b0;
      bit_q  <= '0;
    end else begin
      data_q <= data_d;
      par_q  <= par_d;
      bit_q  <= bit_d;
    end
  end

  // done is registered off the DIV-2 flag so it sits on the final stop cycle.
  always_comb begin
    tx_d    = 1'b1;
    ready_d = (state_d == ST_IDLE);
    done_d  = last_stop && pre;
    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = data_d[bit_d];
      ST_PARITY: tx_d = par_d;
      default:   tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      tx_q    <= 1'b1;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      tx_q    <= tx_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  assign tx    = tx_q;
  assign ready = ready_q;
  assign done  = done_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg: four instances (8N1, 8E1, 8O2, 7N1) at DIV = 10.
module tb_uart_tx_cfg;

  localparam int CF = 1_000_000;
  localparam int BR = 100_000;
  localparam int DV = 10;

  logic       clk = 1'b0;
  logic [3:0] rst_s   = 4'hF;
  logic [3:0] start_s = 4'h0;
  logic [8:0] data_s [4];
  logic [3:0] tx_s, ready_s, done_s;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  uart_tx_cfg #(.CLK_FREQ(CF), .BAUD(BR), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .rstn(rst_s[0]), .start(start_s[0]), .data(data_s[0][7:0]),
    .tx(tx_s[0]), .ready(ready_s[0]), .done(done_s[0]));
  uart_tx_cfg #(.CLK_FREQ(CF), .BAUD(BR), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8e1 (
    .clk(clk), .rstn(rst_s[1]), .start(start_s[1]), .data(data_s[1][7:0]),
    .tx(tx_s[1]), .ready(ready_s[1]), .done(done_s[1]));
  uart_tx_cfg #(.CLK_FREQ(CF), .BAUD(BR), .DATA_BITS(8), .PARITY(1), .STOP_BITS(2)) u_8o2 (
    .clk(clk), .rstn(rst_s[2]), .start(start_s[2]), .data(data_s[2][7:0]),
    .tx(tx_s[2]), .ready(ready_s[2]), .done(done_s[2]));
  uart_tx_cfg #(.CLK_FREQ(CF), .BAUD(BR), .DATA_BITS(7), .PARITY(0), .STOP_BITS(1)) u_7n1 (
    .clk(clk), .rstn(rst_s[3]), .start(start_s[3]), .data(data_s[3][6:0]),
    .tx(tx_s[3]), .ready(ready_s[3]), .done(done_s[3]));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Caller sets start/data so the next edge accepts. Every cycle of the frame
  // is compared against {tx, ready, done}; e counts edges after the accept edge.
  task automatic run_frame(input int inst, input logic [8:0] d, input int nb,
                           input int par, input int ns, input int poke,
                           input bit hold, input logic [8:0] nd, input string name);
    logic   expb [16];
    logic   p;
    logic [2:0] act, want;
    int     n, len;
    expb[0] = 1'b0;
    p = 1'b0;
    for (int i = 0; i < nb; i++) begin
      expb[1 + i] = d[i];
      p = p ^ d[i];
    end
    n = 1 + nb;
    if (par != 0) begin
      expb[n] = (par == 1) ? ~p : p;
      n++;
    end
    for (int i = 0; i < ns; i++) begin
      expb[n] = 1'b1;
      n++;
    end
    len = n * DV;
    step();
    if (!hold) start_s[inst] = 1'b0;
    for (int e = 0; e <= len; e++) begin
      if (e > 0) step();
      if (hold && e == 50) data_s[inst] = nd;
      if (poke >= 0 && e == poke) begin
        start_s[inst] = 1'b1;
        data_s[inst]  = 9'h0FF;
      end
      if (poke >= 0 && e == poke + 1) start_s[inst] = 1'b0;
      act  = {tx_s[inst], ready_s[inst], done_s[inst]};
      want = {(e < len) ? expb[e / DV] : 1'b1, e == len, e == len - 1};
      tests++;
      if (act !== want) begin
        fails++;
        $display("FAIL %s cycle %0d: {tx,ready,done} got %b expected %b", name, e, act, want);
      end
    end
  endtask

  task automatic test_reset();
    rst_s = 4'hF;
    repeat (3) step();
    rst_s = 4'h0;
    step();
    for (int i = 0; i < 4; i++) begin
      tests++;
      if ({tx_s[i], ready_s[i], done_s[i]} !== 3'b110) begin
        fails++;
        $display("FAIL reset inst%0d: got %b expected 110", i, {tx_s[i], ready_s[i], done_s[i]});
      end
    end
  endtask

  task automatic test_8n1();
    start_s[0] = 1'b1; data_s[0] = 9'h0A5;
    run_frame(0, 9'h0A5, 8, 0, 1, -1, 1'b0, 9'h0, "8n1_a5");
  endtask

  task automatic test_parity();
    start_s[1] = 1'b1; data_s[1] = 9'h003;
    run_frame(1, 9'h003, 8, 2, 1, -1, 1'b0, 9'h0, "8e1_03");
    start_s[2] = 1'b1; data_s[2] = 9'h003;
    run_frame(2, 9'h003, 8, 1, 2, -1, 1'b0, 9'h0, "8o2_03");
    start_s[1] = 1'b1; data_s[1] = 9'h0B7;
    run_frame(1, 9'h0B7, 8, 2, 1, -1, 1'b0, 9'h0, "8e1_b7");
  endtask

  task automatic test_7bit();
    start_s[3] = 1'b1; data_s[3] = 9'h0C1;
    run_frame(3, 9'h041, 7, 0, 1, -1, 1'b0, 9'h0, "7n1_41");
  endtask

  task automatic test_ignore_busy();
    start_s[0] = 1'b1; data_s[0] = 9'h012;
    run_frame(0, 9'h012, 8, 0, 1, 30, 1'b0, 9'h0, "busy_start");
    for (int i = 0; i < 25; i++) begin
      step();
      tests++;
      if ({tx_s[0], ready_s[0], done_s[0]} !== 3'b110) begin
        fails++;
        $display("FAIL no_second_frame cycle %0d: got %b expected 110", i,
                 {tx_s[0], ready_s[0], done_s[0]});
      end
    end
  endtask

  task automatic test_back_to_back();
    start_s[0] = 1'b1; data_s[0] = 9'h055;
    run_frame(0, 9'h055, 8, 0, 1, -1, 1'b1, 9'h0AA, "b2b_55");
    run_frame(0, 9'h0AA, 8, 0, 1, -1, 1'b0, 9'h0, "b2b_aa");
  endtask

  task automatic test_mid_reset();
    start_s[0] = 1'b1; data_s[0] = 9'h000;
    step();
    start_s[0] = 1'b0;
    for (int e = 1; e <= 46; e++) step();
    tests++;
    if (tx_s[0] !== 1'b0 || ready_s[0] !== 1'b0) begin
      fails++;
      $display("FAIL pre_reset_busy: tx %b ready %b expected 0 0", tx_s[0], ready_s[0]);
    end
    rst_s[0] = 1'b1;
    step();
    rst_s[0] = 1'b0;
    tests++;
    if ({tx_s[0], ready_s[0], done_s[0]} !== 3'b110) begin
      fails++;
      $display("FAIL mid_reset: got %b expected 110", {tx_s[0], ready_s[0], done_s[0]});
    end
    start_s[0] = 1'b1; data_s[0] = 9'h05A;
    run_frame(0, 9'h05A, 8, 0, 1, -1, 1'b0, 9'h0, "after_reset_5a");
  endtask

  initial begin
    for (int i = 0; i < 4; i++) data_s[i] = '0;
    test_reset();
    test_8n1();
    test_parity();
    test_7bit();
    test_ignore_busy();
    test_back_to_back();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
